dm_pipe: RTL

Parametrised, handshaked data memory for the M stage: serves word, halfword and byte loads and stores with configurable access latency. On every access it checks alignment, address range and access type, and returns an exception code instead of touching memory when a check fails. After reset it clears its contents with an internal sweep. It replaces the single-cycle combinational-read data memory and sits between the M-stage pipeline register and the W stage.

---
 rtl/dm_pkg.sv | 34 +++
 rtl/dm_lane.sv | 65 ++++++
 rtl/dm_pipe.sv | 124 ++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared types for the M-stage data memory: access selects, exception codes, FSM states.
// Optional store trace is enabled with DM_TRACE_EN (see dm_pipe).
package dm_pkg;

    localparam logic [2:0] DM_W  = 3'd0;
    localparam logic [2:0] DM_H  = 3'd1;
    localparam logic [2:0] DM_B  = 3'd2;
    localparam logic [2:0] DM_HU = 3'd3;
    localparam logic [2:0] DM_BU = 3'd4;

    localparam logic [1:0] DM_EXC_NONE     = 2'd0;
    localparam logic [1:0] DM_EXC_MISALIGN = 2'd1;
    localparam logic [1:0] DM_EXC_RANGE    = 2'd2;
    localparam logic [1:0] DM_EXC_SEL      = 2'd3;

    typedef enum logic [1:0] {
        DM_CLEAR,
        DM_IDLE,
        DM_WAIT,
        DM_RESP
    } dm_state_e;

    function automatic logic dm_misaligned(input logic [2:0] sel,
                                           input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        if ((sel == DM_H || sel == DM_HU) && lo[0])
            mis = 1'b1;
        if (sel == DM_W && lo != 2'b00)
            mis = 1'b1;
        return mis;
    endfunction

endpackage

// File: rtl/dm_lane.sv
// Byte-lane steering for the data memory: store byte enables and merge,
// plus sign/zero extension of the selected load lane.
module dm_lane
    import dm_pkg::*;
(
    input  logic [2:0]  sel,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [3:0]  be,
    output logic [31:0] merged,
    output logic [31:0] rdata
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] wrep;

    assign byte_v = word[{addr, 3'b000} +: 8];
    assign half_v = word[{addr[1], 4'b0000} +: 16];

    always_comb begin
        be    = 4'b0000;
        wrep  = wdata;
        rdata = '0;
        unique case (sel)
            DM_W: begin
                be    = 4'b1111;
                rdata = word;
            end
            DM_H: begin
                be    = 4'b0011 << {addr[1], 1'b0};
                wrep  = {2{wdata[15:0]}};
                rdata = {{16{half_v[15]}}, half_v};
            end
            DM_HU: begin
                be    = 4'b0011 << {addr[1], 1'b0};
                wrep  = {2{wdata[15:0]}};
                rdata = {16'h0000, half_v};
            end
            DM_B: begin
                be    = 4'b0001 << addr;
                wrep  = {4{wdata[7:0]}};
                rdata = {{24{byte_v[7]}}, byte_v};
            end
            DM_BU: begin
                be    = 4'b0001 << addr;
                wrep  = {4{wdata[7:0]}};
                rdata = {24'h000000, byte_v};
            end
            default: begin
                be    = 4'b0000;
                rdata = '0;
            end
        endcase
    end

    always_comb begin
        merged = word;
        for (int i = 0; i < 4; i++)
            if (be[i])
                merged[8*i +: 8] = wrep[8*i +: 8];
    end

endmodule

// File: rtl/dm_pipe.sv
// Handshaked M-stage data memory with configurable latency and post-reset clear sweep.
// Define DM_TRACE_EN to print a line for every committed store.
module dm_pipe
    import dm_pkg::*;
#(
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_sel,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_exc
);

    localparam int IW = $clog2(DEPTH);

    dm_state_e   state;
    dm_state_e   state_nx;
    logic [IW-1:0] clr_idx;
    logic [1:0]  lat_cnt;
    logic [31:0] mem [DEPTH];

    logic          acc;
    logic          store_ok;
    logic [1:0]    exc_c;
    logic [IW-1:0] widx;
    logic [31:0]   word;
    logic [3:0]    be;
    logic [31:0]   merged;
    logic [31:0]   ld_data;
    logic          mem_we;
    logic [IW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    assign req_ready = (state == DM_IDLE);
    assign rsp_valid = (state == DM_RESP);
    assign acc       = req_ready && req_valid;
    assign widx      = req_addr[IW+1:2];
    assign word      = mem[widx];

    always_comb begin
        exc_c = DM_EXC_NONE;
        if (req_sel > DM_BU)
            exc_c = DM_EXC_SEL;
        else if (dm_misaligned(req_sel, req_addr[1:0]))
            exc_c = DM_EXC_MISALIGN;
        else if (req_addr[31:2] >= 30'(DEPTH))
            exc_c = DM_EXC_RANGE;
    end

    dm_lane u_lane (
        .sel    (req_sel),
        .addr   (req_addr[1:0]),
        .wdata  (req_wdata),
        .word   (word),
        .be     (be),
        .merged (merged),
        .rdata  (ld_data)
    );

    assign store_ok = acc && req_we && (exc_c == DM_EXC_NONE) && (be != 4'b0000);

    always_comb begin
        state_nx = state;
        unique case (state)
            DM_CLEAR: if (clr_idx == IW'(DEPTH - 1)) state_nx = DM_IDLE;
            DM_IDLE:  if (req_valid) state_nx = (LATENCY > 1) ? DM_WAIT : DM_RESP;
            DM_WAIT:  if (lat_cnt == 2'd0) state_nx = DM_RESP;
            DM_RESP:  if (rsp_ready) state_nx = DM_IDLE;
            default:  state_nx = DM_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= DM_CLEAR;
            clr_idx   <= '0;
            lat_cnt   <= '0;
            rsp_rdata <= '0;
            rsp_exc   <= DM_EXC_NONE;
        end else begin
            state <= state_nx;
            if (state == DM_CLEAR)
                clr_idx <= clr_idx + 1'b1;
            if (acc) begin
                lat_cnt   <= 2'(LATENCY - 2);
                rsp_exc   <= exc_c;
                rsp_rdata <= (!req_we && exc_c == DM_EXC_NONE) ? ld_data : '0;
            end else if (state == DM_WAIT) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
        end
    end

    // Clear writes and stores share the single write port; reset blocks both.
    assign mem_we    = !reset && ((state == DM_CLEAR) || store_ok);
    assign mem_waddr = (state == DM_CLEAR) ? clr_idx : widx;
    assign mem_wdata = (state == DM_CLEAR) ? '0 : merged;

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
`ifdef DM_TRACE_EN
        if (!reset && store_ok)
            $display("%d@%h: *%h <= %h", $time, req_pc,
                     {req_addr[31:2], 2'b00}, merged);
`endif
    end

`ifndef DM_TRACE_EN
    logic unused_pc;
    assign unused_pc = ^req_pc;
`endif

endmodule
